mul_addtree_pipe: RTL and testbench

- Unsigned WIDTH x WIDTH multiplier built as partial-product generation followed by a registered binary adder tree.
- Fully pipelined: accepts one operand pair per clock and emits the 2*WIDTH-bit product a fixed number of cycles later.
- Used as a small arithmetic datapath block wherever a low-width, high-throughput multiply is needed.
- Default configuration is 4x4 -> 8 bits.

---
 rtl/mul_addtree_pipe_if.sv | 28 ++
 rtl/mul_addtree_pipe.sv | 74 +++++++
 tb/tb_mul_addtree_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_addtree_pipe_if.sv
// Operand/product bus for the pipelined adder-tree multiplier.
interface mul_addtree_pipe_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 in_valid;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   mul_out;
    logic                 out_valid;

    // Producer side: drives operands, observes products.
    modport master (
        output in_valid,
        output mul_a,
        output mul_b,
        input  mul_out,
        input  out_valid
    );

    // Multiplier side: consumes operands, drives products.
    modport slave (
        input  in_valid,
        input  mul_a,
        input  mul_b,
        output mul_out,
        output out_valid
    );
endinterface

// File: rtl/mul_addtree_pipe.sv
// Unsigned WIDTH x WIDTH multiplier: registered partial products followed by
// a registered binary adder tree. One operand pair per clock, fixed latency
// LAT = 1 + ceil(log2(WIDTH)), no stalls.
module mul_addtree_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    mul_addtree_pipe_if.slave bus
);

    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned LAT    = 1 + LEVELS;

    // Level k holds ceil(WIDTH / 2^k) nodes; level 0 is the partial products,
    // level LEVELS is the single final sum that drives mul_out.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned CNT = (WIDTH + (1 << k) - 1) >> k;

        logic [PW-1:0] node [CNT];

        if (k == 0) begin : g_pp
            // Partial products: row i is mul_a gated by mul_b[i], shifted by i.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        node[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        node[i] <= bus.mul_b[i] ? (PW'(bus.mul_a) << i) : '0;
                    end
                end
            end
        end else begin : g_add
            localparam int unsigned PREV  = (WIDTH + (1 << (k - 1)) - 1) >> (k - 1);
            localparam int          PAIRS = int'(PREV / 2);
            localparam bit          ODD   = (PREV % 2) == 1;

            // Pairwise sums of the previous level; an odd last node is carried
            // forward unchanged so every path sees the same register count.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < int'(CNT); j++) begin
                        node[j] <= '0;
                    end
                end else begin
                    for (int j = 0; j < PAIRS; j++) begin
                        node[j] <= g_lvl[k-1].node[2*j] + g_lvl[k-1].node[2*j+1];
                    end
                    if (ODD) begin
                        node[CNT-1] <= g_lvl[k-1].node[PREV-1];
                    end
                end
            end
        end
    end

    logic [LAT-1:0] vld;

    // Valid bit travels in lockstep with the data through all LAT stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= {vld[LAT-2:0], bus.in_valid};
        end
    end

    assign bus.mul_out   = g_lvl[LEVELS].node[0];
    assign bus.out_valid = vld[LAT-1];

endmodule

// File: tb/tb_mul_addtree_pipe.sv
// Directed bench for mul_addtree_pipe: reset, ramp, corners, streaming,
// valid gaps, and WIDTH = 3/5/8 instances.
module tb_mul_addtree_pipe;

    localparam int LAT4 = 3;
    localparam int LAT3 = 3;
    localparam int LAT5 = 4;
    localparam int LAT8 = 4;
    localparam int NSW  = 1024;

    logic clk;
    logic rst;

    int n_total = 0;
    int n_pass  = 0;

    mul_addtree_pipe_if #(.WIDTH(4)) b4 ();
    mul_addtree_pipe_if #(.WIDTH(3)) b3 ();
    mul_addtree_pipe_if #(.WIDTH(5)) b5 ();
    mul_addtree_pipe_if #(.WIDTH(8)) b8 ();

    mul_addtree_pipe #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    mul_addtree_pipe #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
    mul_addtree_pipe #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(b5));
    mul_addtree_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference delay line for the WIDTH=4 instance.
    logic [7:0] sh_p [LAT4];
    logic       sh_v [LAT4];

    initial begin
        for (int k = 0; k < LAT4; k++) begin
            sh_p[k] = '0;
            sh_v[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < LAT4; k++) begin
                    sh_p[k] = '0;
                    sh_v[k] = 1'b0;
                end
            end else begin
                for (int k = LAT4 - 1; k > 0; k--) begin
                    sh_p[k] = sh_p[k-1];
                    sh_v[k] = sh_v[k-1];
                end
                sh_p[0] = 8'(b4.mul_a) * 8'(b4.mul_b);
                sh_v[0] = b4.in_valid;
                #1;
                if (!rst) begin
                    check("mon_valid", 32'(b4.out_valid), 32'(sh_v[LAT4-1]));
                    if (sh_v[LAT4-1]) begin
                        check("mon_prod", 32'(b4.mul_out), 32'(sh_p[LAT4-1]));
                    end
                end
            end
        end
    end

    task automatic idle4(input int n);
        @(negedge clk);
        b4.in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Single isolated sample; checks exact latency and the product.
    task automatic run_one(input logic [3:0] a, input logic [3:0] b, input int exp);
        @(negedge clk);
        b4.mul_a    = a;
        b4.mul_b    = b;
        b4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0;
        repeat (LAT4 - 2) @(posedge clk);
        #1;
        check("corner_early_valid", 32'(b4.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("corner_valid", 32'(b4.out_valid), 32'd1);
        check("corner_prod", 32'(b4.mul_out), 32'(exp));
        repeat (LAT4) @(posedge clk);
    endtask

    int ramp_tbl [10] = '{0, 1, 4, 9, 16, 25, 36, 49, 64, 81};
    int ca [5] = '{15, 15, 0, 1, 8};
    int cb [5] = '{15, 0, 15, 15, 8};
    int ce [5] = '{225, 0, 0, 15, 64};

    logic [15:0] h3 [NSW];
    logic [15:0] h5 [NSW];
    logic [15:0] h8 [NSW];

    initial begin
        rst = 1'b1;
        b4.in_valid = 1'b0; b4.mul_a = '0; b4.mul_b = '0;
        b3.in_valid = 1'b0; b3.mul_a = '0; b3.mul_b = '0;
        b5.in_valid = 1'b0; b5.mul_a = '0; b5.mul_b = '0;
        b8.in_valid = 1'b0; b8.mul_a = '0; b8.mul_b = '0;
        #2;
        check("reset_out", 32'(b4.mul_out), 32'd0);
        check("reset_valid", 32'(b4.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT4) @(posedge clk);

        // Ramp: each value held two cycles.
        for (int k = 0; k < 20 + LAT4 - 1; k++) begin
            @(negedge clk);
            if (k < 20) begin
                b4.mul_a    = 4'(k / 2);
                b4.mul_b    = 4'(k / 2);
                b4.in_valid = 1'b1;
            end else begin
                b4.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k >= LAT4 - 1) begin
                check("ramp_valid", 32'(b4.out_valid), 32'd1);
                check("ramp_prod", 32'(b4.mul_out), 32'(ramp_tbl[(k - LAT4 + 1) / 2]));
            end
        end
        idle4(LAT4);

        // Corner operands.
        for (int i = 0; i < 5; i++) begin
            run_one(4'(ca[i]), 4'(cb[i]), ce[i]);
        end

        // Back-to-back random operands.
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            b4.mul_a    = 4'($urandom_range(0, 15));
            b4.mul_b    = 4'($urandom_range(0, 15));
            b4.in_valid = 1'b1;
        end
        idle4(LAT4 + 1);

        // Alternating valid pattern.
        for (int k = 0; k < 20 + LAT4; k++) begin
            @(negedge clk);
            b4.mul_a    = 4'(k + 3);
            b4.mul_b    = 4'(k + 7);
            b4.in_valid = (k < 20) && (k % 2 == 0);
            @(posedge clk);
            #1;
            if (k >= LAT4 - 1) begin
                check("gap_valid", 32'(b4.out_valid),
                      32'(((k - LAT4 + 1) < 20) && ((k - LAT4 + 1) % 2 == 0)));
            end
        end
        idle4(LAT4);

        // Asynchronous reset with the pipeline full.
        @(negedge clk);
        b4.mul_a    = 4'd9;
        b4.mul_b    = 4'd7;
        b4.in_valid = 1'b1;
        repeat (LAT4) @(posedge clk);
        #1;
        check("prefill_prod", 32'(b4.mul_out), 32'd63);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", 32'(b4.mul_out), 32'd0);
        check("async_rst_valid", 32'(b4.out_valid), 32'd0);
        @(negedge clk);
        b4.in_valid = 1'b0;
        b4.mul_a    = '0;
        b4.mul_b    = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < LAT4 + 2; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_out", 32'(b4.mul_out), 32'd0);
            check("post_rst_valid", 32'(b4.out_valid), 32'd0);
        end

        // Width sweep: 3 and 5 exhaustive, 8 random, all streamed together.
        for (int k = 0; k < NSW + LAT8; k++) begin
            @(negedge clk);
            if (k < NSW) begin
                b3.mul_a = 3'(k >> 3);
                b3.mul_b = 3'(k);
                b3.in_valid = 1'b1;
                h3[k] = 16'(b3.mul_a) * 16'(b3.mul_b);
                b5.mul_a = 5'(k >> 5);
                b5.mul_b = 5'(k);
                b5.in_valid = 1'b1;
                h5[k] = 16'(b5.mul_a) * 16'(b5.mul_b);
                b8.mul_a = 8'($urandom_range(0, 255));
                b8.mul_b = 8'($urandom_range(0, 255));
                b8.in_valid = 1'b1;
                h8[k] = 16'(b8.mul_a) * 16'(b8.mul_b);
            end else begin
                b3.in_valid = 1'b0;
                b5.in_valid = 1'b0;
                b8.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k == LAT3 - 2) check("w3_early_valid", 32'(b3.out_valid), 32'd0);
            if (k == LAT5 - 2) check("w5_early_valid", 32'(b5.out_valid), 32'd0);
            if (k == LAT8 - 2) check("w8_early_valid", 32'(b8.out_valid), 32'd0);
            if (k >= LAT3 - 1 && k - LAT3 + 1 < NSW) begin
                check("w3_valid", 32'(b3.out_valid), 32'd1);
                check("w3_prod", 32'(b3.mul_out), 32'(h3[k - LAT3 + 1]));
            end
            if (k >= LAT5 - 1 && k - LAT5 + 1 < NSW) begin
                check("w5_valid", 32'(b5.out_valid), 32'd1);
                check("w5_prod", 32'(b5.mul_out), 32'(h5[k - LAT5 + 1]));
            end
            if (k >= LAT8 - 1 && k - LAT8 + 1 < NSW) begin
                check("w8_valid", 32'(b8.out_valid), 32'd1);
                check("w8_prod", 32'(b8.mul_out), 32'(h8[k - LAT8 + 1]));
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("w3_drained", 32'(b3.out_valid), 32'd0);
        check("w8_drained", 32'(b8.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
